// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: core stores fill a byte FIFO that is
// serialized on uart_txd; a combinational status word lets firmware poll for space.
module io_uart_tx #(
   parameter int CLK_FREQ_HZ = 50000000,
   parameter int BAUD        = 115200,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] IO_mem_addr,
   input  logic [31:0] IO_mem_wdata,
   input  logic        IO_mem_wr,
   output logic [31:0] IO_mem_rdata,
   output logic        uart_txd,
   output logic        tx_busy
);
   localparam int DIV = CLK_FREQ_HZ / BAUD;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t        r_state, w_state_n;
   logic [CW-1:0] r_cnt, w_cnt_n;
   logic [2:0]    r_bit, w_bit_n;
   logic [7:0]    r_shift, w_shift_n;
   logic          r_txd, w_txd_n;
   logic [AW:0]   r_wptr, r_rptr, w_level;
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic          r_ovf;
   logic [13:0]   w_wa;
   logic [7:0]    w_head, w_level8;
   logic          w_sel_data, w_sel_stat, w_empty, w_full, w_pop, w_push;
   logic          w_ovf_set, w_ovf_clr, w_bit_end, w_unused;

   assign w_wa       = IO_mem_addr[15:2];
   assign w_sel_data = w_wa[1];
   assign w_sel_stat = w_wa[2];
   assign w_unused   = ^{IO_mem_addr[31:16], IO_mem_addr[1:0], w_wa[13:3], w_wa[0],
                         IO_mem_wdata[31:8]};

   // Extra pointer MSB distinguishes full from empty when the low bits match.
   assign w_empty   = (r_wptr == r_rptr);
   assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_level   = r_wptr - r_rptr;
   assign w_level8  = 8'(w_level);
   assign w_head    = r_mem[r_rptr[AW-1:0]];
   assign w_push    = IO_mem_wr && w_sel_data && (!w_full || w_pop);
   assign w_ovf_set = IO_mem_wr && w_sel_data && w_full && !w_pop;
   assign w_ovf_clr = IO_mem_wr && w_sel_stat && IO_mem_wdata[2];
   assign w_bit_end = (r_cnt == CNT_LAST);

   assign tx_busy  = !w_empty || (r_state != S_IDLE);
   assign uart_txd = r_txd;

   // Status read mux; all other addresses read as zero.
   always_comb begin
      IO_mem_rdata = 32'd0;
      if (w_sel_stat) begin
         IO_mem_rdata = {20'd0, w_level8, w_empty, r_ovf, tx_busy, w_full};
      end else begin
         IO_mem_rdata = 32'd0;
      end
   end

   // FIFO storage write port.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr[AW-1:0]] <= IO_mem_wdata[7:0];
      end
   end

   // Transmit FSM next-state, baud counter, shifter and line level.
   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt + 1'b1;
      w_bit_n   = r_bit;
      w_shift_n = r_shift;
      w_txd_n   = r_txd;
      w_pop     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_n = '0;
            if (!w_empty) begin
               w_pop     = 1'b1;
               w_shift_n = w_head;
               w_state_n = S_START;
               w_txd_n   = 1'b0;
            end else begin
               w_txd_n = 1'b1;
            end
         end
         S_START: begin
            if (w_bit_end) begin
               w_state_n = S_DATA;
               w_cnt_n   = '0;
               w_bit_n   = 3'd0;
               w_txd_n   = r_shift[0];
            end else begin
               w_state_n = S_START;
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               w_cnt_n   = '0;
               w_shift_n = {1'b0, r_shift[7:1]};
               if (r_bit == 3'd7) begin
                  w_state_n = S_STOP;
                  w_txd_n   = 1'b1;
               end else begin
                  w_bit_n = r_bit + 3'd1;
                  w_txd_n = r_shift[1];
               end
            end else begin
               w_state_n = S_DATA;
            end
         end
         S_STOP: begin
            if (w_bit_end) begin
               w_cnt_n = '0;
               // Back-to-back frames: reload straight into START with no idle bit.
               if (!w_empty) begin
                  w_pop     = 1'b1;
                  w_shift_n = w_head;
                  w_state_n = S_START;
                  w_txd_n   = 1'b0;
               end else begin
                  w_state_n = S_IDLE;
                  w_txd_n   = 1'b1;
               end
            end else begin
               w_state_n = S_STOP;
            end
         end
         default: begin
            w_state_n = S_IDLE;
            w_cnt_n   = '0;
            w_txd_n   = 1'b1;
         end
      endcase
   end

   // State, pointer and overflow registers; overflow set wins over clear.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_bit   <= 3'd0;
         r_shift <= 8'd0;
         r_txd   <= 1'b1;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_bit   <= w_bit_n;
         r_shift <= w_shift_n;
         r_txd   <= w_txd_n;
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         if (w_ovf_set)      r_ovf <= 1'b1;
         else if (w_ovf_clr) r_ovf <= 1'b0;
      end
   end
endmodule

// File: tb/tb_io_uart_tx.sv
// Self-checking bench for io_uart_tx with DIV=4, using a queue-based model of
// the FIFO and of the expected line waveform.
module tb_io_uart_tx;
   localparam int DIV   = 4;
   localparam int DEPTH = 8;
   localparam int FRAME = 10 * DIV;
   localparam logic [31:0] A_DATA = 32'h0040_0008;
   localparam logic [31:0] A_STAT = 32'h0040_0010;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic        wr = 1'b0;
   logic [31:0] rdata;
   logic        txd, busy;

   int n_checks = 0;
   int n_fail   = 0;

   byte unsigned m_fifo[$];
   bit           m_line[$];
   bit           m_ovf = 1'b0;

   io_uart_tx #(.CLK_FREQ_HZ(1000), .BAUD(250), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .resetn(resetn), .IO_mem_addr(addr), .IO_mem_wdata(wdata),
      .IO_mem_wr(wr), .IO_mem_rdata(rdata), .uart_txd(txd), .tx_busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic bit m_busy();
      return (m_line.size() > 0) || (m_fifo.size() > 0);
   endfunction

   function automatic bit m_txd();
      return (m_line.size() > 0) ? m_line[0] : 1'b1;
   endfunction

   function automatic logic [31:0] m_status();
      return {20'd0, 8'(m_fifo.size()), (m_fifo.size() == 0), m_ovf, m_busy(),
              (m_fifo.size() == DEPTH)};
   endfunction

   // One clock of the reference: the line queue holds one entry per remaining cycle.
   task automatic model_step();
      int sz;
      bit pop, push, acc, clr, v;
      byte unsigned b;
      if (!resetn) begin
         m_fifo.delete();
         m_line.delete();
         m_ovf = 1'b0;
         return;
      end
      sz   = m_fifo.size();
      pop  = (m_line.size() <= 1) && (sz > 0);
      push = wr && addr[3];
      clr  = wr && addr[4] && wdata[2];
      acc  = push && ((sz < DEPTH) || pop);
      if (m_line.size() > 1) begin
         void'(m_line.pop_front());
      end else if (pop) begin
         b = m_fifo.pop_front();
         m_line.delete();
         for (int k = 0; k < 10; k++) begin
            v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            for (int j = 0; j < DIV; j++) m_line.push_back(v);
         end
      end else begin
         m_line.delete();
      end
      if (push && !acc) m_ovf = 1'b1;
      else if (clr)     m_ovf = 1'b0;
      if (acc) m_fifo.push_back(wdata[7:0]);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      wr    = 1'b1;
      tick();
      wr = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      tick();
      n_checks++;
      if (txd !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: txd=%b busy=%b, required txd=1 busy=0", txd, busy);
      end
      resetn = 1'b1;
      addr   = A_STAT;
      #1;
      n_checks++;
      if (rdata !== 32'h8 || rdata !== m_status()) begin
         n_fail++;
         $display("FAIL reset_status: got %h required %h", rdata, 32'h8);
      end
   endtask

   // Waveform checked against the 8N1 frame pattern derived directly from the byte.
   task automatic test_single(input logic [7:0] b);
      int idx;
      logic exp_txd, exp_busy;
      bus_write(A_DATA, {24'd0, b});
      for (int c = 1; c <= 44; c++) begin
         tick();
         idx      = (c - 1) / DIV;
         exp_txd  = (c > FRAME) ? 1'b1 : (idx == 0) ? 1'b0 : (idx <= 8) ? b[idx-1] : 1'b1;
         exp_busy = (c <= FRAME);
         n_checks++;
         if (txd !== exp_txd || busy !== exp_busy) begin
            n_fail++;
            $display("FAIL single_frame byte=%h cycle %0d: txd=%b busy=%b required txd=%b busy=%b",
                     b, c, txd, busy, exp_txd, exp_busy);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) bus_write(A_DATA, $urandom);
      addr = A_STAT;
      #1;
      n_checks++;
      if (rdata[11:4] !== 8'd2 || rdata !== m_status()) begin
         n_fail++;
         $display("FAIL b2b_level: status=%h required %h (level 2)", rdata, m_status());
      end
      for (int k = 1; k <= 125; k++) begin
         tick();
         n_checks++;
         if (txd !== m_txd() || busy !== m_busy() || (k < 119 && busy !== 1'b1)
             || (k == 119 && busy !== 1'b0)) begin
            n_fail++;
            $display("FAIL b2b_line cycle %0d: txd=%b busy=%b required txd=%b busy=%b",
                     k, txd, busy, m_txd(), (k < 119));
         end
      end
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < 10; i++) begin
         bus_write(A_DATA, $urandom);
         addr = A_STAT;
         #1;
         n_checks++;
         if (rdata !== m_status() || (i == 7 && rdata[0] !== 1'b0)
             || (i == 8 && (rdata[0] !== 1'b1 || rdata[11:4] !== 8'd8))
             || (i == 9 && rdata[2] !== 1'b1)) begin
            n_fail++;
            $display("FAIL fill_status write %0d: got %h required %h", i + 1, rdata, m_status());
         end
      end
      bus_write(A_STAT, 32'h4);
      #1;
      n_checks++;
      if (rdata[2] !== 1'b0 || rdata !== m_status()) begin
         n_fail++;
         $display("FAIL overflow_clear: got %h required %h", rdata, m_status());
      end
   endtask

   task automatic test_push_at_pop();
      int guard = 0;
      while (m_line.size() != 1 && guard < 60) begin
         tick();
         guard++;
         n_checks++;
         if (txd !== m_txd()) begin
            n_fail++;
            $display("FAIL pap_line: txd=%b required %b", txd, m_txd());
         end
      end
      n_checks++;
      if (guard >= 60) begin
         n_fail++;
         $display("FAIL pap_wait: frame end not reached, waited %0d required <60", guard);
      end
      bus_write(A_DATA, $urandom);
      addr = A_STAT;
      #1;
      n_checks++;
      if (rdata[11:4] !== 8'd8 || rdata[2] !== 1'b0 || rdata[0] !== 1'b1
          || rdata !== m_status()) begin
         n_fail++;
         $display("FAIL push_at_pop: status=%h required %h", rdata, m_status());
      end
   endtask

   task automatic test_reset_midframe();
      int guard = 0;
      while (m_line.size() != FRAME - 17 && guard < 100) begin
         tick();
         guard++;
      end
      n_checks++;
      if (guard >= 100) begin
         n_fail++;
         $display("FAIL rst_wait: bit 3 not reached, waited %0d required <100", guard);
      end
      #2;
      resetn = 1'b0;
      #1;
      n_checks++;
      if (txd !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: txd=%b busy=%b required txd=1 busy=0", txd, busy);
      end
      tick();
      resetn = 1'b1;
      addr   = A_STAT;
      #1;
      n_checks++;
      if (rdata !== 32'h8) begin
         n_fail++;
         $display("FAIL rst_status: got %h required %h", rdata, 32'h8);
      end
      bus_write(A_DATA, $urandom);
      for (int c = 1; c <= 44; c++) begin
         tick();
         n_checks++;
         if (txd !== m_txd() || busy !== m_busy() || (c == 41 && busy !== 1'b0)) begin
            n_fail++;
            $display("FAIL post_reset_frame cycle %0d: txd=%b busy=%b required txd=%b busy=%b",
                     c, txd, busy, m_txd(), m_busy());
         end
      end
   endtask

   task automatic test_reads();
      logic [31:0] addrs [4];
      logic [31:0] first;
      addrs[0] = 32'h0040_0004;
      addrs[1] = A_DATA;
      addrs[2] = 32'h0040_0020;
      addrs[3] = $urandom & 32'hFFFF_FFEF;
      for (int i = 0; i < 4; i++) begin
         addr = addrs[i];
         #1;
         n_checks++;
         if (rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL nonstatus_read addr=%h: got %h required 0", addrs[i], rdata);
         end
      end
      bus_write(A_DATA, $urandom);
      addr = A_STAT;
      #1;
      first = m_status();
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (rdata !== m_status() || (i == 0 && rdata !== first)) begin
            n_fail++;
            $display("FAIL status_repeat read %0d: got %h required %h", i, rdata, m_status());
         end
         tick();
         #1;
      end
      for (int c = 0; c < 45; c++) tick();
      addr = A_STAT;
      #1;
      n_checks++;
      if (rdata !== 32'h8 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL final_idle: status=%h busy=%b required 00000008 busy=0", rdata, busy);
      end
   endtask

   initial begin
      test_reset();
      test_single(8'h55);
      test_single(8'($urandom));
      test_back_to_back();
      test_fill_overflow();
      test_push_at_pop();
      test_reset_midframe();
      test_reads();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
